// File: rtl/param_wakeup_timer.sv
// param_wakeup_timer: enable-gated wakeup counter with a Gray-coded prescaler,
// one-shot / periodic compare, sticky wakeup and optional sticky overrun flag.
// Build option: define WAKEUP_OVF_EN to implement the overrun flag; otherwise
// the ovf port is tied to 0.
module param_wakeup_timer #(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned PRS_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             prs,
    input  logic [PRS_W-1:0] div,
    input  logic [CNT_W-1:0] cmp,
    input  logic             mode,
    input  logic             wakeup_ack,
    output logic [CNT_W-1:0] out,
    output logic             wakeup,
    output logic             ovf,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_out;
    logic [CNT_W-1:0] w_out_nxt;
    logic [PRS_W-1:0] r_gc;
    logic [PRS_W-1:0] w_gc_nxt;
    logic             r_wakeup;
    logic             w_wakeup_nxt;

    logic [PRS_W-1:0] w_gc_bin;
    logic [PRS_W-1:0] w_gc_inc;
    logic [CNT_W-1:0] w_out_inc;
    logic             w_run_en;
    logic             w_prs_hit;
    logic             w_tick;
    logic             w_match;

    // Gray-to-binary decode of the prescaler register
    function automatic logic [PRS_W-1:0] gray2bin(input logic [PRS_W-1:0] g);
        logic [PRS_W-1:0] b;
        b[PRS_W-1] = g[PRS_W-1];
        for (int i = int'(PRS_W) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign w_gc_bin  = gray2bin(r_gc);
    assign w_gc_inc  = w_gc_bin + PRS_W'(1);
    assign w_out_inc = r_out + CNT_W'(1);
    assign w_run_en  = (r_state == ST_RUN) && en;
    // >= (not ==) so a div lowered below the current count ticks at once
    assign w_prs_hit = (w_gc_bin >= div);
    assign w_tick    = w_run_en && (!prs || w_prs_hit);
    assign w_match   = w_tick && (w_out_inc == cmp);

    // Next-state, count, prescaler and wakeup logic
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_gc_nxt     = r_gc;
        w_wakeup_nxt = r_wakeup;

        // match wins over a same-cycle ack
        if (w_match) begin
            w_wakeup_nxt = 1'b1;
        end else if (wakeup_ack) begin
            w_wakeup_nxt = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_out_nxt   = '0;
                    w_gc_nxt    = '0;
                end
            end
            ST_RUN: begin
                if (w_run_en) begin
                    if (!prs || w_prs_hit) begin
                        w_gc_nxt = '0;
                    end else begin
                        w_gc_nxt = w_gc_inc ^ (w_gc_inc >> 1);
                    end
                end
                if (w_match) begin
                    if (mode) begin
                        w_out_nxt = '0;
                    end else begin
                        w_out_nxt   = cmp;
                        w_state_nxt = ST_DONE;
                    end
                end else if (w_tick) begin
                    w_out_nxt = w_out_inc;
                end
            end
            ST_DONE: begin
                if (wakeup_ack) begin
                    w_state_nxt  = ST_IDLE;
                    w_out_nxt    = '0;
                    w_gc_nxt     = '0;
                    w_wakeup_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_out_nxt    = '0;
                w_gc_nxt     = '0;
                w_wakeup_nxt = 1'b0;
            end
        endcase
    end

    // State, count, prescaler and wakeup registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= ST_IDLE;
            r_out    <= '0;
            r_gc     <= '0;
            r_wakeup <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_gc     <= w_gc_nxt;
            r_wakeup <= w_wakeup_nxt;
        end
    end

`ifdef WAKEUP_OVF_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Overrun: match while an unacknowledged wakeup is pending; cleared on DONE exit
    always_comb begin
        w_ovf_nxt = r_ovf;
        if ((r_state == ST_DONE) && wakeup_ack) begin
            w_ovf_nxt = 1'b0;
        end else if (w_match && r_wakeup && !wakeup_ack) begin
            w_ovf_nxt = 1'b1;
        end
    end

    // Overrun register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign out    = r_out;
    assign wakeup = r_wakeup;
    assign state  = r_state;

endmodule

// File: doc/param_wakeup_timer.md
PARAM_WAKEUP_TIMER -- requirements
Module: param_wakeup_timer

Interface
REQ-001 Parameter CNT_W, default 20: width of the main count and compare value.
REQ-002 Parameter PRS_W, default 8: width of the Gray-coded prescaler and its divide value.
REQ-003 Port list (name, direction, width, meaning):
- clk, input, 1: single clock; all state SHALL change on its rising edge.
- clr_n, input, 1: reset, asynchronous, active-low.
- en, input, 1: count enable; low pauses counting.
- prs, input, 1: 1 selects the prescaler tick; 0 ticks every enabled cycle.
- div, input, PRS_W: prescaler terminal value.
- cmp, input, CNT_W: wakeup compare value.
- mode, input, 1: 0 selects one-shot; 1 selects periodic.
- wakeup_ack, input, 1: clears wakeup.
- out, output, CNT_W: current count.
- wakeup, output, 1: sticky wakeup flag.
- ovf, output, 1: sticky overrun flag.
- state, output, 2: FSM state (IDLE=0, RUN=1, DONE=2).

Function
REQ-004 Prescaler SHALL be a PRS_W-bit Gray-code register gc that advances by one Gray step per cycle while state=RUN, en=1 and prs=1.
REQ-005 Prescaler tick SHALL assert when the binary decode of gc is >= div; on that cycle gc SHALL load 0. Tick period is div+1 clocks, with div=0 giving a tick every cycle.
REQ-006 When prs=0, tick SHALL equal en in RUN and gc SHALL hold 0.
REQ-007 A div reduced below the current prescaler count SHALL cause a tick on the next enabled cycle, with no wrap through 2^PRS_W.
REQ-008 On a tick in RUN, out SHALL increment modulo 2^CNT_W.
REQ-009 Match SHALL be tick AND (out+1 mod 2^CNT_W == cmp). cmp=0 therefore matches on the all-ones to 0 wrap, giving a period of 2^CNT_W ticks.
REQ-010 In one-shot mode, a match SHALL load out with cmp, move the FSM from RUN to DONE, and freeze out and gc.
REQ-011 In periodic mode, a match SHALL load out with 0 and the FSM SHALL stay in RUN.
REQ-012 wakeup SHALL set on the clock edge that registers a match, so it is visible on the same edge as the out update.
REQ-013 wakeup SHALL clear on wakeup_ack=1 with no match pending in that cycle. Match and ack in the same cycle: wakeup stays 1 and ovf is not set.
REQ-014 ovf SHALL set when a match occurs while wakeup=1 and wakeup_ack=0. ovf SHALL clear only on reset or on the DONE/IDLE transition.
REQ-015 FSM transitions:
- IDLE to RUN when en=1; out=0 and gc=0 on entry.
- RUN with en=0: hold out and gc, stay in RUN.
- DONE to IDLE on wakeup_ack=1; this clears out, gc, wakeup and ovf.
- State encoding 3 SHALL never occur and SHALL recover to IDLE.
REQ-016 Changing mode or cmp in RUN SHALL take effect on the next tick; no retroactive match SHALL occur.

Reset
REQ-017 clr_n=0 SHALL asynchronously force out=0, gc=0, wakeup=0, ovf=0 and state=IDLE, including mid-count and in DONE.
REQ-018 Reset deassertion SHALL be honoured on the next clk edge. The first possible increment is the second edge after deassertion with en=1 (IDLE to RUN, then tick).

Configuration
REQ-019 Macro WAKEUP_OVF_EN:
- Defined: ovf SHALL behave per REQ-014.
- Undefined: the ovf port SHALL remain, be tied to 0, and its logic SHALL be absent. All other behaviour is identical.

Verification
REQ-020 Reset release and pause:
- Stimulus: clr_n low 4 cycles, then en=1, prs=0, mode=1, cmp=10.
- Response: out counts 0..9, returns to 0, and wakeup rises on the 10th tick.
- Stimulus: en=0 for 5 cycles.
- Response: out holds.
REQ-021 Prescaler:
- Stimulus: prs=1, div=3, cmp=4, mode=0.
- Response: out increments every 4 clocks; out=4 and state=DONE after 16 clocks; gc follows Gray sequence 0,1,3,2.
REQ-022 Overrun:
- Stimulus: periodic, cmp=2, prs=0, no ack.
- Response: wakeup at the 2nd tick, ovf at the 4th tick.
- Stimulus: ack coincident with a match.
- Response: wakeup stays 1 and ovf does not set.
REQ-023 Full-range wrap:
- Stimulus: CNT_W=4, cmp=0, periodic.
- Response: wakeup on the 15 to 0 transition, after 16 ticks.
REQ-024 Mid-operation events:
- Stimulus: clr_n pulsed low at out=7.
- Response: immediate out=0, state=IDLE.
- Stimulus: div lowered from 200 to 2 while gc decodes to 50.
- Response: tick on the next cycle.
REQ-025 Configuration coverage:
- Run REQ-022 with WAKEUP_OVF_EN undefined.
- Response: ovf stays 0 throughout.
